// File: rtl/usb_data_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : usb_data_buffer
// Description : 64-byte first-word-fall-through byte FIFO shared between the
//               AHB-Lite slave and the USB transmitter/receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_data_buffer #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       store_tx_data,
    input  logic [7:0] tx_data,
    input  logic       get_rx_data,
    output logic [7:0] rx_data,
    input  logic       store_rx_packet_data,
    input  logic [7:0] rx_packet_data,
    input  logic       get_tx_packet_data,
    output logic [7:0] tx_packet_data,
    output logic [6:0] buffer_occupancy
);

    localparam int         c_AW   = $clog2(DEPTH);
    localparam logic [6:0] c_FULL = 7'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [6:0]      r_count;

    logic            w_push_req;
    logic            w_pop_req;
    logic            w_pop_ok;
    logic            w_push_ok;
    logic            w_empty;
    logic [7:0]      w_wdata;
    logic [7:0]      w_head;

    assign w_empty    = (r_count == 7'd0);
    assign w_push_req = store_tx_data | store_rx_packet_data;
    assign w_pop_req  = get_rx_data | get_tx_packet_data;

    // A same-cycle push never makes an empty FIFO poppable, but a same-cycle
    // pop does free a slot for a push into a full FIFO.
    assign w_pop_ok   = w_pop_req & ~w_empty;
    assign w_push_ok  = w_push_req & ((r_count != c_FULL) | w_pop_ok);

    // Receiver byte wins when both producers strobe together.
    assign w_wdata    = store_rx_packet_data ? rx_packet_data : tx_data;

    assign w_head         = w_empty ? 8'h00 : r_mem[r_rptr];
    assign rx_data        = w_head;
    assign tx_packet_data = w_head;
    assign buffer_occupancy = r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 7'd0;
        end else if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 7'd0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 7'd1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 7'd1;
            end
        end
    end

    // Clear leaves stored bytes in place; only reset scrubs them.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (!clear && w_push_ok) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

endmodule
`default_nettype wire
